// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width and 4-bit opcodes used by the
// datapath ALU and by every block that borrows it.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_OP_AND = 4'b0000;
  localparam logic [3:0] ALU_OP_OR  = 4'b0001;
  localparam logic [3:0] ALU_OP_ADD = 4'b0010;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;

endpackage : alu_pkg

// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned shift-and-add multiplier (low WIDTH bits of A*B).
// Owns no adder: it drives the shared ALU through ALU_Operation/Data1/Data2
// and consumes ALU_result/ZERO in the same cycle. Additions accumulate the
// partial product; idle OR cycles test whether any multiplier bits remain.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int         WIDTH  = ALU_WIDTH,
  parameter logic [3:0] OP_AND = ALU_OP_AND,
  parameter logic [3:0] OP_OR  = ALU_OP_OR,
  parameter logic [3:0] OP_ADD = ALU_OP_ADD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Product,
  output logic [3:0]       ALU_Operation,
  output logic [WIDTH-1:0] Data1,
  output logic [WIDTH-1:0] Data2,
  input  logic [WIDTH-1:0] ALU_result,
  input  logic             ZERO
);

  localparam int               CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;          // shifted multiplicand
  logic [WIDTH-1:0] q_q, q_d;          // remaining multiplier bits
  logic [WIDTH-1:0] acc_q, acc_d;      // running partial product
  logic [CW-1:0]    count_q, count_d;  // RUN cycles completed
  logic [WIDTH-1:0] product_q, product_d;

  assign Product = product_q;

  // State register and datapath registers.
  // NOTE: every register here is a handful of flops, not a memory array, so
  // all of them take the asynchronous reset; that also makes a reset in RUN
  // discard the operation and clear Product immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Next-state, datapath updates and ALU drive.
  always_comb begin
    // NOTE: every output of this block is assigned a default first so no
    // path through the case statement can infer a latch.
    state_d       = state_q;
    m_d           = m_q;
    q_d           = q_q;
    acc_d         = acc_q;
    count_d       = count_q;
    product_d     = product_q;
    ALU_Operation = OP_AND;
    Data1         = '0;
    Data2         = '0;
    busy          = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = Multiplicand;
          q_d     = Multiplier;
          acc_d   = '0;
          count_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy = 1'b1;
        if (q_q[0]) begin
          // Current multiplier bit set: add the shifted multiplicand.
          ALU_Operation = OP_ADD;
          Data1         = acc_q;
          Data2         = m_q;
          acc_d         = ALU_result;
        end else begin
          // Bit clear: use the ALU to ask whether any higher bits remain.
          ALU_Operation = OP_OR;
          Data1         = {1'b0, q_q[WIDTH-1:1]};
          Data2         = '0;
        end
        m_d     = m_q << 1;
        q_d     = q_q >> 1;
        count_d = count_q + CW'(1);
        if ((!q_q[0] && ZERO) || (count_q == LAST)) begin
          product_d = acc_d;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule : alu_mul_seq

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned shift-and-add multiplier returning the low 32 bits of the product (RV32 MUL semantics for unsigned operands).
- Acts as the initiator on the ALU operation interface: it drives ALU_Operation/Data1/Data2 and consumes ALU_result/ZERO from an external ALU instance, so no adder is duplicated.
- Sits beside the datapath ALU; a top-level mux grants it the ALU while busy.

Parameters:
- WIDTH, 32, operand/product width; must equal ALU width.
- OP_AND, 4'b0000, ALU opcode for AND (idle drive value).
- OP_OR, 4'b0001, ALU opcode for OR (termination test).
- OP_ADD, 4'b0010, ALU opcode for ADD (accumulate).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- Multiplicand  in  WIDTH  operand A; latched on accepted start.
- Multiplier  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; Product is valid from this cycle.
- Product  out  WIDTH  low WIDTH bits of A*B; held until the next done.
- ALU_Operation  out  4  opcode to ALU.
- Data1  out  WIDTH  ALU operand 1.
- Data2  out  WIDTH  ALU operand 2.
- ALU_result  in  WIDTH  combinational ALU result.
- ZERO  in  1  ALU result-is-zero flag.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state=IDLE; busy=0; done=0; Product=0. Internal registers M, Q and ACC are 0, count=0.
- Reset mid-RUN aborts the operation: no done pulse is produced and Product is cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - ALU driven with OP_AND, Data1=0, Data2=0.
  - On start=1: M<=Multiplicand, Q<=Multiplier, ACC<=0, count<=0, go to RUN.
- RUN, per cycle, all outputs combinational from registers:
  - If Q[0]=1: drive OP_ADD, Data1=ACC, Data2=M, and ACC<=ALU_result (wraps mod 2^WIDTH, carry discarded).
  - If Q[0]=0: drive OP_OR, Data1={1'b0,Q[WIDTH-1:1]}, Data2=0. ACC unchanged.
  - Every RUN cycle: M<=M<<1, Q<=Q>>1, count<=count+1.
  - Exit to DONE when (Q[0]=0 and ZERO=1), i.e. no remaining multiplier bits, or when count=WIDTH-1.
  - On exit: Product<=ACC as updated this cycle.
- DONE: done=1 for exactly one cycle, ALU driven as in IDLE, then go to IDLE. start is ignored in DONE.
- start in RUN or DONE is ignored: no queuing and no restart.
- Latency from start accept to done = RUN cycles + 1, where RUN cycles = min(WIDTH, index of highest set bit of Multiplier + 2).
  - Multiplier=0: 1 RUN cycle, done 2 cycles after start.
  - Multiplier bit 31 set: 32 RUN cycles via the count limit.
- The ALU response is trusted to be combinational in the same cycle; no wait states.
- Product is never partially visible: it updates only at RUN exit.

Decomposition:
- Package alu_pkg holds the shared 4-bit opcode constants (AND 0000, OR 0001, ADD 0010, SUB 0110) and WIDTH=32. Both the ALU and this block import them; the parameters above default from it.
- No sub-module: the FSM and shift registers are a single module. The ALU is instantiated by the parent, and the bench instantiates the real ALU wired to this block.

Test Plan:
- Basic product: start with A=7, B=6 -> done after 4 RUN cycles + 1, Product=0x0000002A, busy high exactly during RUN.
- Zero multiplier: A=0x12345678, B=0 -> one RUN cycle with OP_OR seen on ALU_Operation, done 2 cycles after start, Product=0.
- Full width and wrap: A=0xFFFFFFFF, B=0xFFFFFFFF -> 32 RUN cycles, Product=0x00000001. Then A=0x00010000, B=0x00010000 -> Product=0 (overflow truncated).
- start ignored while busy: A=3, B=5, pulse start with A=9, B=9 during RUN -> Product=15, exactly one done pulse, no second operation.
- Reset mid-operation: assert rst asynchronously in RUN cycle 3 of A=0xFFFF, B=0xFFFF -> busy, done and Product are 0 immediately. Next start with A=2, B=3 -> Product=6.
- Random regression: 1000 random A/B pairs -> Product=(A*B) mod 2^32. Assert ALU_Operation is only ever OP_AND, OP_OR or OP_ADD, and that done is always single-cycle.
